// File: rtl/fnd_uart_formatter_if.sv
// Handshake bundle between the FND controller, the formatter and
// the UART transmitter.
interface fnd_uart_formatter_if;
    logic [15:0] i_data;
    logic [2:0]  i_mode;
    logic        i_send;
    logic        i_tx_busy;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_done;

    modport master (
        output i_data,
        output i_mode,
        output i_send,
        output i_tx_busy,
        input  o_tx_data,
        input  o_tx_start,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_data,
        input  i_mode,
        input  i_send,
        input  i_tx_busy,
        output o_tx_data,
        output o_tx_start,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/fnd_uart_formatter.sv
// Turns a latched four-digit BCD reading into an ASCII frame and
// feeds it byte by byte to a UART transmitter.
module fnd_uart_formatter #(
    parameter int SEND_CRLF = 1
) (
    input logic                  clk,
    input logic                  reset,
    fnd_uart_formatter_if.slave  bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] WAIT_H = 3'd3;
    localparam logic [2:0] WAIT_L = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam logic [2:0] LAST_IDX =
        (SEND_CRLF != 0) ? 3'd7 : 3'd5;

    logic [2:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] data_q, data_d;
    logic        dht_q, dht_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  byte_sel;
    logic        mode_ok;

    function automatic logic [7:0] asc(
        input logic [3:0] d
    );
        return (d > 4'd9) ? 8'h3F : {4'h3, d};
    endfunction

    assign mode_ok = (bus.i_mode == 3'b010) ||
                     (bus.i_mode == 3'b100);

    // SR04: D d3 d2 d1 . d0   DHT11: H d3 d2 T d1 d0
    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            3'd0: byte_sel = dht_q ? 8'h48 : 8'h44;
            3'd1: byte_sel = asc(data_q[15:12]);
            3'd2: byte_sel = asc(data_q[11:8]);
            3'd3: byte_sel = dht_q ? 8'h54
                                   : asc(data_q[7:4]);
            3'd4: byte_sel = dht_q ? asc(data_q[7:4])
                                   : 8'h2E;
            3'd5: byte_sel = asc(data_q[3:0]);
            3'd6: byte_sel = 8'h0D;
            3'd7: byte_sel = 8'h0A;
            default: byte_sel = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        dht_d      = dht_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_send && mode_ok) begin
                    data_d  = bus.i_data;
                    dht_d   = bus.i_mode[2];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                idx_d   = 3'd0;
                state_d = START;
            end
            START: begin
                if (!bus.i_tx_busy) begin
                    tx_data_d  = byte_sel;
                    tx_start_d = 1'b1;
                    state_d    = WAIT_H;
                end
            end
            WAIT_H: begin
                if (bus.i_tx_busy) begin
                    state_d = WAIT_L;
                end
            end
            WAIT_L: begin
                if (!bus.i_tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = START;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == LOAD)   ||
                 (state_d == START)  ||
                 (state_d == WAIT_H) ||
                 (state_d == WAIT_L);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            data_q     <= 16'h0000;
            dht_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            dht_q      <= dht_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;

endmodule

// File: tb/tb_fnd_uart_formatter.sv
// Bench: two formatters (with and without CR LF) against a UART
// model and a frame-building reference model.
module tb_fnd_uart_formatter;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fnd_uart_formatter_if ifa();
    fnd_uart_formatter_if ifb();

    fnd_uart_formatter #(.SEND_CRLF(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );
    fnd_uart_formatter #(.SEND_CRLF(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    int total = 0;
    int bad = 0;

    // UART model: accepts a start when idle, busy 10 cycles per byte
    int cnt_a, cnt_b;
    logic force_busy = 1'b0;
    assign ifa.i_tx_busy = (cnt_a != 0) || force_busy;
    assign ifb.i_tx_busy = (cnt_b != 0) || force_busy;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_a <= 0;
            cnt_b <= 0;
        end else begin
            if (cnt_a != 0) cnt_a <= cnt_a - 1;
            else if (ifa.o_tx_start) cnt_a <= 10;
            if (cnt_b != 0) cnt_b <= cnt_b - 1;
            else if (ifb.o_tx_start) cnt_b <= 10;
        end
    end

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int starts_a = 0, starts_b = 0;
    int done_a = 0, done_b = 0;
    int busyc_a = 0, busyc_b = 0;

    always @(negedge clk) begin
        if (ifa.o_tx_start) begin
            qa.push_back(ifa.o_tx_data);
            starts_a++;
        end
        if (ifb.o_tx_start) begin
            qb.push_back(ifb.o_tx_data);
            starts_b++;
        end
        if (ifa.o_done) done_a++;
        if (ifb.o_done) done_b++;
        if (ifa.o_busy) busyc_a++;
        if (ifb.o_busy) busyc_b++;
    end

    function automatic logic [7:0] enc(input int v);
        if (v > 9) return 8'h3F;
        return 8'(48 + v);
    endfunction

    function automatic bq_t model(
        input bit dht, input logic [15:0] d, input bit crlf
    );
        bq_t f;
        int d3 = int'(d[15:12]);
        int d2 = int'(d[11:8]);
        int d1 = int'(d[7:4]);
        int d0 = int'(d[3:0]);
        if (dht) f = '{"H", enc(d3), enc(d2), "T", enc(d1), enc(d0)};
        else     f = '{"D", enc(d3), enc(d2), enc(d1), ".", enc(d0)};
        if (crlf) begin
            f.push_back(8'h0D);
            f.push_back(8'h0A);
        end
        return f;
    endfunction

    task automatic chk(
        input string tag, input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(
        input logic [2:0] m, input logic [15:0] d,
        input logic s
    );
        ifa.i_mode = m; ifb.i_mode = m;
        ifa.i_data = d; ifb.i_data = d;
        ifa.i_send = s; ifb.i_send = s;
    endtask

    task automatic chk_q(
        input string tag, input bq_t got, input int base,
        input bq_t exp
    );
        chk({tag, "_len"}, got.size() - base, exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            if (base + k < got.size())
                chk($sformatf("%s_b%0d", tag, k),
                    got[base + k], exp[k]);
        end
    endtask

    task automatic run_frame(
        input logic [2:0] m, input logic [15:0] d,
        input int hold, input bit lat,
        input bit resend, input bit chg
    );
        int ba = qa.size();
        int bb = qb.size();
        int da = done_a;
        int db = done_b;
        int sa = starts_a;
        int n = 0;
        bit sent2 = 0;
        force_busy = (hold > 0);
        drive(m, d, 1'b1);
        tick();
        ifa.i_send = 1'b0; ifb.i_send = 1'b0;
        if (lat) begin
            tick();
            chk("lat_c1", ifa.o_tx_start, 1'b0);
            tick();
            chk("lat_c2", ifa.o_tx_start, 1'b1);
            chk("lat_b0", ifa.o_tx_data, m[2] ? 8'h48 : 8'h44);
        end
        if (hold > 0) begin
            repeat (hold) tick();
            chk("hold_nostart", starts_a - sa, 0);
            force_busy = 1'b0;
        end
        while ((done_a == da || done_b == db) && n < 3000) begin
            tick();
            n++;
            if (resend && !sent2 && qa.size() - ba == 3) begin
                ifa.i_send = 1'b1; ifb.i_send = 1'b1;
                tick();
                ifa.i_send = 1'b0; ifb.i_send = 1'b0;
                sent2 = 1;
            end
            if (chg && qa.size() - ba >= 2) begin
                ifa.i_data = 16'h9999; ifb.i_data = 16'h9999;
                ifa.i_mode = ~m;       ifb.i_mode = ~m;
            end
        end
        repeat (40) tick();
        chk("frame_timeout", n < 3000, 1'b1);
        chk_q("crlf1", qa, ba, model(m[2], d, 1));
        chk_q("crlf0", qb, bb, model(m[2], d, 0));
        chk("done_a", done_a - da, 1);
        chk("done_b", done_b - db, 1);
        chk("idle_a", ifa.o_busy, 1'b0);
    endtask

    initial begin
        logic [2:0] bad_modes[5];
        int sa, ba, da, n;
        bad_modes = '{3'b001, 3'b000, 3'b011, 3'b111, 3'b110};
        drive(3'b000, 16'h0000, 1'b0);
        repeat (3) tick();
        chk("rst_a", {ifa.o_tx_data, ifa.o_tx_start,
                      ifa.o_busy, ifa.o_done}, 0);
        chk("rst_b", {ifb.o_tx_data, ifb.o_tx_start,
                      ifb.o_busy, ifb.o_done}, 0);
        reset = 1'b1;
        repeat (2) tick();

        run_frame(3'b010, 16'h1234, 0, 1, 0, 0);
        run_frame(3'b100, 16'h5623, 0, 1, 0, 0);
        run_frame(3'b010, 16'hA9F0, 0, 0, 0, 0);

        foreach (bad_modes[i]) begin
            sa = starts_a;
            n = busyc_a;
            drive(bad_modes[i], 16'h1234, 1'b1);
            tick();
            ifa.i_send = 1'b0; ifb.i_send = 1'b0;
            repeat (20) tick();
            chk($sformatf("inv_start_%0d", i), starts_a - sa, 0);
            chk($sformatf("inv_busy_%0d", i), busyc_a - n, 0);
        end

        run_frame(3'b100, 16'h0987, 50, 0, 0, 0);
        run_frame(3'b010, 16'h4321, 0, 0, 1, 0);
        run_frame(3'b010, 16'h1234, 0, 0, 0, 1);

        // abort a frame after its third byte
        ba = qa.size();
        da = done_a;
        drive(3'b010, 16'h1234, 1'b1);
        tick();
        ifa.i_send = 1'b0; ifb.i_send = 1'b0;
        n = 0;
        while (qa.size() - ba < 3 && n < 1000) begin
            tick();
            n++;
        end
        chk("rst_mid_reach", n < 1000, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_mid_a", {ifa.o_tx_data, ifa.o_tx_start,
                          ifa.o_busy, ifa.o_done}, 0);
        chk("rst_mid_b", {ifb.o_tx_data, ifb.o_tx_start,
                          ifb.o_busy, ifb.o_done}, 0);
        repeat (3) tick();
        reset = 1'b1;
        sa = starts_a;
        repeat (30) tick();
        chk("rst_no_done", done_a - da, 0);
        chk("rst_no_restart", starts_a - sa, 0);
        chk("rst_no_busy", ifa.o_busy, 1'b0);
        run_frame(3'b010, 16'h1234, 0, 1, 0, 0);

        for (int r = 0; r < 6; r++) begin
            run_frame($urandom_range(0, 1) ? 3'b100 : 3'b010,
                      16'($urandom), 0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fnd_uart_formatter.md
FND_UART_FORMATTER -- requirements
Module: fnd_uart_formatter

Interface
REQ-001 SHALL have parameter SEND_CRLF, default 1; 1 appends CR LF to each frame, 0 omits them.
REQ-002 SHALL have port clk  in  1  system clock, 100 MHz, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-004 SHALL have port i_data  in  16  four BCD digits {d3,d2,d1,d0}, fed from the FND controller's uart_send_data output.
REQ-005 SHALL have port i_mode  in  3  one-hot source select: 3'b010 = SR04, 3'b100 = DHT11, anything else = no source.
REQ-006 SHALL have port i_send  in  1  single-cycle send request.
REQ-007 SHALL have port i_tx_busy  in  1  UART transmitter busy; it goes high the cycle after the transmitter accepts a start and stays high until the byte finishes.
REQ-008 SHALL have port o_tx_data  out  8  ASCII byte presented to the transmitter.
REQ-009 SHALL have port o_tx_start  out  1  single-cycle byte start strobe.
REQ-010 SHALL have port o_busy  out  1  high while a frame is in progress.
REQ-011 SHALL have port o_done  out  1  single-cycle pulse after the last byte of a frame completes.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, START, WAIT_H, WAIT_L, DONE.
REQ-013 IDLE: on i_send=1 with i_mode of 010 or 100, SHALL latch i_data and i_mode and go to LOAD; any other i_mode ignores the request.
REQ-014 LOAD: SHALL clear byte index to 0, set o_busy=1, then go to START.
REQ-015 START: when i_tx_busy=0, SHALL drive o_tx_data = byte[index] and pulse o_tx_start for exactly one cycle, then go to WAIT_H; while i_tx_busy=1 it holds without strobing.
REQ-016 WAIT_H: SHALL wait for i_tx_busy=1, then go to WAIT_L.
REQ-017 WAIT_L: on i_tx_busy=0, SHALL go to DONE if index = last, else increment index and go to START.
REQ-018 DONE: SHALL pulse o_done for one cycle, clear o_busy, and return to IDLE.
REQ-019 SR04 frame SHALL be 'D', d3, d2, d1, '.', d0, then CR, LF if SEND_CRLF=1.
REQ-020 DHT11 frame SHALL be 'H', d3, d2, 'T', d1, d0, then CR, LF if SEND_CRLF=1.
REQ-021 Frame length SHALL be 8 bytes with SEND_CRLF=1 and 6 bytes with SEND_CRLF=0; last index is 7 or 5 respectively.
REQ-022 Digit encoding SHALL be 0x30 + digit for values 0-9 and 0x3F ('?') for values 10-15.
REQ-023 i_send asserted while o_busy=1 SHALL be ignored and not queued.
REQ-024 Changes on i_data or i_mode during a frame SHALL NOT alter the bytes being sent.
REQ-025 o_tx_data SHALL hold its value from the o_tx_start cycle until the next o_tx_start.
REQ-026 Minimum latency SHALL be 2 cycles from accepted i_send to the first o_tx_start, when i_tx_busy=0.

Reset
REQ-027 While reset=0, SHALL hold the FSM in IDLE, index 0, o_tx_data 8'h00, and o_tx_start, o_busy, o_done at 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no o_done; after release, only a new i_send starts a frame.

Verification
REQ-029 SR04: i_mode=010, i_data=16'h1234, i_send pulse, transmitter model busy for 10 cycles per byte -> bytes 44 31 32 33 2E 34 0D 0A, one o_done pulse.
REQ-030 DHT11: i_mode=100, i_data=16'h5623 -> bytes 48 35 36 54 32 33 0D 0A; with SEND_CRLF=0 -> the first 6 bytes only.
REQ-031 Invalid input: i_mode=001 with i_send -> no o_tx_start, o_busy stays 0; i_data=16'hA9F0 in SR04 mode -> 44 3F 39 3F 2E 30 0D 0A.
REQ-032 Busy hold-off: i_tx_busy held high for 50 cycles at start -> no strobe until busy falls, then a single strobe; a second i_send mid-frame -> exactly 8 bytes sent and one o_done.
REQ-033 Reset mid-frame: reset=0 after byte 3 -> all outputs zero immediately, no o_done; a following i_send sends a complete fresh frame.
REQ-034 Data change: i_data changed to 16'h9999 after byte 1 -> the frame still carries the originally latched 16'h1234 digits.
